// File: rtl/counter_timer_ctrl_if.sv
// Bus between the timer control stage, its host, and the 8-bit up counter.
// slave = the control block, master = whoever drives start/stop and the counter.
interface counter_timer_ctrl_if;
  logic       start;
  logic       stop;
  logic       periodic;
  logic [7:0] reload_val;
  logic [7:0] cnt_val;
  logic       cnt_co;
  logic       done_clr;
  logic       cnt_ld;
  logic [7:0] cnt_par;
  logic       cnt_cen;
  logic       tick;
  logic       busy;
  logic       done;
  logic       ovf;

  modport slave (
    input  start, stop, periodic, reload_val, cnt_val, cnt_co, done_clr,
    output cnt_ld, cnt_par, cnt_cen, tick, busy, done, ovf
  );

  modport master (
    output start, stop, periodic, reload_val, cnt_val, cnt_co, done_clr,
    input  cnt_ld, cnt_par, cnt_cen, tick, busy, done, ovf
  );
endinterface

// File: rtl/counter_timer_ctrl.sv
// Control stage for an external 8-bit up counter: loads the start count,
// gates counting through a prescaler, and reports expiry as a one-cycle tick
// plus sticky done/ovf flags. One-shot or auto-reloading periodic operation.
module counter_timer_ctrl #(
  parameter int PRESCALE = 4
) (
  input logic                  clk,
  input logic                  rst,
  counter_timer_ctrl_if.slave  bus
);

  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0] LP_LAST = PSW'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t         r_state, w_state_nxt;
  logic [PSW-1:0] r_pre,   w_pre_nxt;
  logic [7:0]     r_rval;
  logic           r_per;
  logic           r_done;
  logic           r_ovf;

  logic w_pulse;
  logic w_expiry;
  logic w_start;
  logic w_tick;

  // stop beats start; an accepted start (re)captures the reload settings
  assign w_start  = bus.start & ~bus.stop;
  assign w_pulse  = (r_state == S_RUN) && (r_pre == LP_LAST);
  assign w_expiry = w_pulse & bus.cnt_co;
  // a restart in the expiry cycle swallows the tick
  assign w_tick   = w_expiry & ~w_start;

  assign bus.cnt_ld  = (r_state == S_LOAD) | (w_expiry & r_per);
  assign bus.cnt_par = r_rval;
  assign bus.cnt_cen = w_pulse & ~bus.cnt_co;
  assign bus.tick    = w_tick;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.ovf     = r_ovf;

  // next-state and prescaler update
  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    if (bus.stop) begin
      w_state_nxt = S_IDLE;
      w_pre_nxt   = '0;
    end else if (bus.start) begin
      w_state_nxt = S_LOAD;
      w_pre_nxt   = '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          w_state_nxt = S_RUN;
          w_pre_nxt   = '0;
        end
        S_RUN: begin
          w_pre_nxt = w_pulse ? '0 : r_pre + PSW'(1);
          if (w_expiry && !r_per) w_state_nxt = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // state and prescaler registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pre   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
    end
  end

  // reload value and mode latched on every accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rval <= '0;
      r_per  <= 1'b0;
    end else if (w_start) begin
      r_rval <= bus.reload_val;
      r_per  <= bus.periodic;
    end
  end

  // sticky status; an expiry outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_tick) begin
      r_done <= 1'b1;
      if (r_done && !bus.done_clr) r_ovf <= 1'b1;
    end else if (bus.done_clr) begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end
  end

  // the counter's terminal-count flag must agree with its parallel output
  a_co_match: assert property (@(posedge clk) disable iff (!rst)
    bus.cnt_co == (bus.cnt_val == 8'hFF));

endmodule
